// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the 16x16 register file write port.
// Each requester owns a one-entry slot; a round-robin pointer settles contention.
module regfile_wb_arbiter #(
  parameter int DATA_W  = 16,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [3:0]        a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [3:0]        b_reg,
  input  logic [DATA_W-1:0] b_data,
  input  logic              hold,
  output logic [3:0]        DstReg,
  output logic              WriteReg,
  output logic [DATA_W-1:0] DstData,
  output logic [15:0]       reg_busy,
  output logic              grant_a,
  output logic              grant_b
);

  logic              a_vld_p1, b_vld_p1;
  logic [3:0]        a_reg_p1, b_reg_p1;
  logic [DATA_W-1:0] a_data_p1, b_data_p1;
  logic              rr_b;
  logic              a_take, b_take;

  // stage p0 -> p1: grant and accept decisions from the slot flops
  always_comb begin
    grant_a = ~hold & a_vld_p1 & (~b_vld_p1 | ~rr_b);
    grant_b = ~hold & b_vld_p1 & (~a_vld_p1 |  rr_b);
  end

  assign a_ready = ~a_vld_p1 | grant_a;
  assign b_ready = ~b_vld_p1 | grant_b;
  assign a_take  = a_valid & a_ready;
  assign b_take  = b_valid & b_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_vld_p1 <= 1'b0;
      b_vld_p1 <= 1'b0;
      rr_b     <= 1'b0;
    end else begin
      if (a_take)       a_vld_p1 <= 1'b1;
      else if (grant_a) a_vld_p1 <= 1'b0;
      if (b_take)       b_vld_p1 <= 1'b1;
      else if (grant_b) b_vld_p1 <= 1'b0;
      // pointer only moves when both slots competed for the port
      if (grant_a && b_vld_p1)      rr_b <= 1'b1;
      else if (grant_b && a_vld_p1) rr_b <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (a_take) begin
      a_reg_p1  <= a_reg;
      a_data_p1 <= a_data;
    end
    if (b_take) begin
      b_reg_p1  <= b_reg;
      b_data_p1 <= b_data;
    end
  end

  // stage p1 -> register file: drive the write port from the granted slot
  always_comb begin
    DstReg   = 4'd0;
    DstData  = '0;
    WriteReg = 1'b0;
    if (grant_a) begin
      DstReg   = a_reg_p1;
      DstData  = a_data_p1;
      WriteReg = !(DROP_R0 && (a_reg_p1 == 4'd0));
    end else if (grant_b) begin
      DstReg   = b_reg_p1;
      DstData  = b_data_p1;
      WriteReg = !(DROP_R0 && (b_reg_p1 == 4'd0));
    end
  end

  always_comb begin
    reg_busy = 16'h0000;
    if (a_vld_p1) reg_busy[a_reg_p1] = 1'b1;
    if (b_vld_p1) reg_busy[b_reg_p1] = 1'b1;
    if (DROP_R0)  reg_busy[0] = 1'b0;
  end

endmodule
